rv_fetch_unit: RTL and testbench

//  Parametrised instruction-fetch stage for the rvMagic pipeline, replacing the fixed single-cycle IF path.

---
 rtl/rv_fetch_unit.sv | 144 ++++++++++++++
 tb/tb_rv_fetch_unit.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv_fetch_unit.sv
// Instruction-fetch stage: pipelined req/gnt/rvalid fetch into a prefetch FIFO towards ID,
// with redirect handling that drains responses belonging to squashed requests.
module rv_fetch_unit #(
    parameter int unsigned           ADDR_WIDTH      = 32,
    parameter int unsigned           INST_WIDTH      = 32,
    parameter int unsigned           FIFO_DEPTH      = 4,
    parameter int unsigned           MAX_OUTSTANDING = 2,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC        = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic                  I_MEM_req,
    output logic [ADDR_WIDTH-1:0] I_MEM_addr,
    input  logic                  I_MEM_gnt,
    input  logic                  I_MEM_rvalid,
    input  logic [INST_WIDTH-1:0] I_MEM_rdata,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_addr,
    output logic                  inst_valid,
    input  logic                  inst_ready,
    output logic [INST_WIDTH-1:0] inst_data,
    output logic [ADDR_WIDTH-1:0] inst_pc,
    output logic [ADDR_WIDTH-1:0] inst_nextPc
);

    localparam int unsigned OUT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned AQ_W  = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int unsigned SUM_W = ((OUT_W > CNT_W) ? OUT_W : CNT_W) + 1;

    typedef struct packed {
        logic [INST_WIDTH-1:0] inst;
        logic [ADDR_WIDTH-1:0] pc;
    } fetch_entry_t;

    logic [ADDR_WIDTH-1:0] pc_q;
    logic [OUT_W-1:0]      out_q;
    logic [OUT_W-1:0]      disc_q;
    logic [OUT_W-1:0]      out_n;

    logic [ADDR_WIDTH-1:0] aq_mem [MAX_OUTSTANDING];
    logic [AQ_W-1:0]       aq_wr;
    logic [AQ_W-1:0]       aq_rd;

    fetch_entry_t          fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      fifo_wr;
    logic [PTR_W-1:0]      fifo_rd;
    logic [CNT_W-1:0]      fifo_cnt;
    fetch_entry_t          head;

    logic                  credit_ok;
    logic                  fire;
    logic                  rsp_ok;
    logic                  rsp_keep;
    logic                  rsp_drop;
    logic                  pop;
    logic [ADDR_WIDTH-1:0] redir_pc;

    // Address queue depth need not be a power of two, so wrap explicitly.
    function automatic logic [AQ_W-1:0] aq_next(input logic [AQ_W-1:0] p);
        aq_next = (p == AQ_W'(MAX_OUTSTANDING - 1)) ? '0 : p + AQ_W'(1);
    endfunction

    // Squashed requests still occupy an outstanding slot until their response drains.
    assign credit_ok = (out_q < OUT_W'(MAX_OUTSTANDING)) &&
                       ((SUM_W'(out_q) + SUM_W'(fifo_cnt)) < SUM_W'(FIFO_DEPTH));

    assign I_MEM_req  = credit_ok & ~redirect_valid & rst_n;
    assign I_MEM_addr = pc_q;

    assign fire     = I_MEM_req & I_MEM_gnt;
    assign rsp_ok   = I_MEM_rvalid && (out_q != '0);
    assign rsp_keep = rsp_ok && !redirect_valid && (disc_q == '0);
    assign rsp_drop = rsp_ok && !redirect_valid && (disc_q != '0);
    assign pop      = inst_valid & inst_ready & ~redirect_valid;
    assign out_n    = out_q + OUT_W'(fire) - OUT_W'(rsp_ok);
    assign redir_pc = redirect_addr & ~ADDR_WIDTH'(3);

    assign head        = fifo_mem[fifo_rd];
    assign inst_valid  = (fifo_cnt != '0);
    assign inst_data   = inst_valid ? head.inst : '0;
    assign inst_pc     = inst_valid ? head.pc : '0;
    assign inst_nextPc = inst_valid ? head.pc + ADDR_WIDTH'(4) : '0;

    // Control state: PC, credit counters, queue pointers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q     <= RESET_PC;
            out_q    <= '0;
            disc_q   <= '0;
            aq_wr    <= '0;
            aq_rd    <= '0;
            fifo_wr  <= '0;
            fifo_rd  <= '0;
            fifo_cnt <= '0;
        end else begin
            out_q <= out_n;
            if (redirect_valid) begin
                // No request fires here, so everything still outstanding is stale.
                pc_q     <= redir_pc;
                disc_q   <= out_n;
                aq_wr    <= '0;
                aq_rd    <= '0;
                fifo_wr  <= '0;
                fifo_rd  <= '0;
                fifo_cnt <= '0;
            end else begin
                if (fire) begin
                    pc_q  <= pc_q + ADDR_WIDTH'(4);
                    aq_wr <= aq_next(aq_wr);
                end
                if (rsp_drop) begin
                    disc_q <= disc_q - OUT_W'(1);
                end
                if (rsp_keep) begin
                    aq_rd   <= aq_next(aq_rd);
                    fifo_wr <= fifo_wr + PTR_W'(1);
                end
                if (pop) begin
                    fifo_rd <= fifo_rd + PTR_W'(1);
                end
                fifo_cnt <= fifo_cnt + CNT_W'(rsp_keep) - CNT_W'(pop);
            end
        end
    end

    // Storage arrays carry no reset; validity is tracked by the pointers above.
    always_ff @(posedge clk) begin
        if (fire) begin
            aq_mem[aq_wr] <= pc_q;
        end
        if (rsp_keep) begin
            fifo_mem[fifo_wr] <= '{inst: I_MEM_rdata, pc: aq_mem[aq_rd]};
        end
    end

    a_no_orphan_rvalid: assert property (@(posedge clk) disable iff (!rst_n)
        !(I_MEM_rvalid && (out_q == '0)));

    a_no_fifo_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(rsp_keep && !pop && (fifo_cnt == CNT_W'(FIFO_DEPTH))));

endmodule

// File: tb/tb_rv_fetch_unit.sv
// Directed bench for rv_fetch_unit: two instances (RESET_PC 0 and 0xFFFF_FFF8) with
// behavioural instruction memories whose response latency is set per step.
`timescale 1ns/1ps
module tb_rv_fetch_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // DUT A signals
    logic        rst_n;
    logic        req_a;
    logic [31:0] addr_a;
    logic        gnt_a;
    logic        rvalid_a = 1'b0;
    logic [31:0] rdata_a  = '0;
    logic        redir_valid;
    logic [31:0] redir_addr;
    logic        valid_a;
    logic        ready_a;
    logic [31:0] data_a;
    logic [31:0] pc_a;
    logic [31:0] npc_a;

    // DUT B signals
    logic        rst_b;
    logic        req_b;
    logic [31:0] addr_b;
    logic        gnt_b;
    logic        rvalid_b = 1'b0;
    logic [31:0] rdata_b  = '0;
    logic        redir_valid_b;
    logic [31:0] redir_addr_b;
    logic        valid_b;
    logic        ready_b;
    logic [31:0] data_b;
    logic [31:0] pc_b;
    logic [31:0] npc_b;

    rv_fetch_unit #(
        .ADDR_WIDTH(32), .INST_WIDTH(32), .FIFO_DEPTH(4), .MAX_OUTSTANDING(2),
        .RESET_PC(32'h0000_0000)
    ) u_dut_a (
        .clk(clk), .rst_n(rst_n),
        .I_MEM_req(req_a), .I_MEM_addr(addr_a), .I_MEM_gnt(gnt_a),
        .I_MEM_rvalid(rvalid_a), .I_MEM_rdata(rdata_a),
        .redirect_valid(redir_valid), .redirect_addr(redir_addr),
        .inst_valid(valid_a), .inst_ready(ready_a), .inst_data(data_a),
        .inst_pc(pc_a), .inst_nextPc(npc_a)
    );

    rv_fetch_unit #(
        .ADDR_WIDTH(32), .INST_WIDTH(32), .FIFO_DEPTH(4), .MAX_OUTSTANDING(2),
        .RESET_PC(32'hFFFF_FFF8)
    ) u_dut_b (
        .clk(clk), .rst_n(rst_b),
        .I_MEM_req(req_b), .I_MEM_addr(addr_b), .I_MEM_gnt(gnt_b),
        .I_MEM_rvalid(rvalid_b), .I_MEM_rdata(rdata_b),
        .redirect_valid(redir_valid_b), .redirect_addr(redir_addr_b),
        .inst_valid(valid_b), .inst_ready(ready_b), .inst_data(data_b),
        .inst_pc(pc_b), .inst_nextPc(npc_b)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h1300_0013;
    endfunction

    // Memory A: in-order responses, rvalid seen by the DUT 'lat' edges after the grant.
    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] due;
    } pend_t;

    pend_t       pend_q[$];
    logic [31:0] cyc      = '0;
    logic [31:0] lat      = 32'd1;
    int          n_grants = 0;

    always @(posedge clk) begin
        if (!rst_n) begin
            pend_q.delete();
            rvalid_a <= 1'b0;
            rdata_a  <= '0;
            n_grants = 0;
        end else begin
            if (req_a && gnt_a) begin
                pend_q.push_back('{addr: addr_a, due: cyc + lat - 32'd1});
                n_grants++;
            end
            rvalid_a <= 1'b0;
            if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
                rvalid_a <= 1'b1;
                rdata_a  <= mem_word(pend_q[0].addr);
                void'(pend_q.pop_front());
            end
        end
        cyc = cyc + 32'd1;
    end

    // Memory B: zero-wait, always granting.
    always @(posedge clk) begin
        if (!rst_b) begin
            rvalid_b <= 1'b0;
            rdata_b  <= '0;
        end else begin
            rvalid_b <= req_b;
            rdata_b  <= mem_word(addr_b);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic wait_valid_a(input int max_cycles, output logic found);
        found = 1'b0;
        for (int i = 0; i < max_cycles && !found; i++) begin
            @(negedge clk);
            if (valid_a) found = 1'b1;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic found;
        rst_n = 1'b0; rst_b = 1'b0;
        gnt_a = 1'b1; ready_a = 1'b1; redir_valid = 1'b0; redir_addr = '0;
        gnt_b = 1'b1; ready_b = 1'b1; redir_valid_b = 1'b0; redir_addr_b = '0;
        lat = 32'd1;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_req",   32'(req_a),   32'd0);
        check("rst_valid", 32'(valid_a), 32'd0);
        check("rst_data",  data_a,       32'd0);
        check("rst_pc",    pc_a,         32'd0);
        check("rst_npc",   npc_a,        32'd0);
        check("rst_req_b", 32'(req_b),   32'd0);

        // 1: zero-wait memory, ID always ready
        rst_n = 1'b1;
        #1;
        check("t1_req",   32'(req_a), 32'd1);
        check("t1_addr0", addr_a,     32'h0);
        @(negedge clk);
        check("t1_addr1",  addr_a,       32'h4);
        check("t1_no_val", 32'(valid_a), 32'd0);
        @(negedge clk);
        for (int k = 0; k < 6; k++) begin
            check("t1_valid", 32'(valid_a), 32'd1);
            check("t1_pc",    pc_a,         32'(4 * k));
            check("t1_npc",   npc_a,        32'(4 * k + 4));
            check("t1_data",  data_a,       mem_word(32'(4 * k)));
            @(negedge clk);
        end

        // 2: ID stalled fills the FIFO, then drains in order
        rst_n = 1'b0; ready_a = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        check("t2_grants",  32'(n_grants), 32'd4);
        check("t2_req_off", 32'(req_a),    32'd0);
        check("t2_valid",   32'(valid_a),  32'd1);
        check("t2_head_pc", pc_a,          32'h0);
        @(negedge clk);
        check("t2_hold_pc",   pc_a,   32'h0);
        check("t2_hold_data", data_a, mem_word(32'h0));
        ready_a = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            check("t2_drain_val", 32'(valid_a), 32'd1);
            check("t2_drain_pc",  pc_a,         32'(4 * k));
        end

        // 3: 3-cycle latency, two in flight, redirect to unaligned 0x103
        rst_n = 1'b0; lat = 32'd3;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("t3_req_blocked", 32'(req_a), 32'd0);
        redir_valid = 1'b1; redir_addr = 32'h0000_0103;
        @(negedge clk);
        redir_valid = 1'b0;
        check("t3_flush_val", 32'(valid_a), 32'd0);
        check("t3_new_addr",  addr_a,       32'h100);
        wait_valid_a(12, found);
        check("t3_found", 32'(found), 32'd1);
        check("t3_pc",    pc_a,       32'h100);
        check("t3_npc",   npc_a,      32'h104);
        check("t3_data",  data_a,     mem_word(32'h100));
        @(negedge clk);
        check("t3_pc2",   pc_a,       32'h104);

        // 4: redirect coinciding with a response and an ID pop
        rst_n = 1'b0; lat = 32'd1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("t4_pre_val", 32'(valid_a), 32'd1);
        check("t4_pre_pc",  pc_a,         32'h4);
        redir_valid = 1'b1; redir_addr = 32'h0000_0200;
        @(negedge clk);
        check("t4_flush_val", 32'(valid_a), 32'd0);
        check("t4_req_redir", 32'(req_a),   32'd0);
        check("t4_new_addr",  addr_a,       32'h200);
        redir_valid = 1'b0;
        wait_valid_a(8, found);
        check("t4_found", 32'(found), 32'd1);
        check("t4_pc",    pc_a,       32'h200);
        check("t4_npc",   npc_a,      32'h204);

        // 5: RESET_PC near the top of the address space wraps
        rst_n = 1'b0;
        rst_b = 1'b1;
        #1;
        check("t5_addr0", addr_b, 32'hFFFF_FFF8);
        repeat (2) @(negedge clk);
        check("t5_val",  32'(valid_b), 32'd1);
        check("t5_pc0",  pc_b,         32'hFFFF_FFF8);
        check("t5_npc0", npc_b,        32'hFFFF_FFFC);
        @(negedge clk);
        check("t5_pc1",  pc_b,         32'hFFFF_FFFC);
        check("t5_npc1", npc_b,        32'h0000_0000);
        @(negedge clk);
        check("t5_pc2",  pc_b,         32'h0000_0000);
        check("t5_npc2", npc_b,        32'h0000_0004);
        check("t5_data", data_b,       mem_word(32'h0));

        // 6: reset with two requests outstanding
        lat = 32'd3;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("t6_req_blocked", 32'(req_a), 32'd0);
        rst_n = 1'b0;
        @(negedge clk);
        check("t6_rst_val", 32'(valid_a), 32'd0);
        check("t6_rst_req", 32'(req_a),   32'd0);
        rst_n = 1'b1;
        #1;
        check("t6_restart_req",  32'(req_a), 32'd1);
        check("t6_restart_addr", addr_a,     32'h0);
        wait_valid_a(10, found);
        check("t6_found", 32'(found), 32'd1);
        check("t6_pc",    pc_a,       32'h0);
        check("t6_data",  data_a,     mem_word(32'h0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
